// File: rtl/full_adder_bist_pkg.sv
// Shared types and helpers for the full-adder built-in self-test driver/checker.
package full_adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_VECTORS = 8;

    // Reference sum of three single-bit operands: {carry,sum}.
    function automatic logic [1:0] adder_expect(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage

// File: rtl/full_adder_bist.sv
// Sweeps all eight operand vectors into two full-adder variants, holding each vector
// for SETTLE_CYCLES+1 cycles, and records per-vector pass/fail plus a cross-DUT disagreement flag.
module full_adder_bist
    import full_adder_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] y_struct,
    input  logic [1:0] y_other,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_vec,
    output logic [3:0] err_count,
    output logic       disagree
);

    localparam int                CNT_W    = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [2:0]        LAST_VEC = 3'(NUM_VECTORS - 1);

    state_e           state_reg;
    logic [2:0]       vec_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [1:0] exp_value;
    logic       vec_fail;
    logic       sample_now;

    // The vector counter wraps 7 -> 0 on the final sample, so the operands idle at 0 in DONE.
    assign {a, b, c} = vec_reg;

    always_comb begin
        exp_value  = adder_expect(vec_reg[2], vec_reg[1], vec_reg[0]);
        vec_fail   = (y_struct != exp_value) || (y_other != exp_value);
        sample_now = (state_reg == RUN) && (cnt_reg == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            vec_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
            disagree  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= RUN;
                        vec_reg   <= '0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_vec  <= '0;
                        err_count <= '0;
                        disagree  <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample_now) begin
                        cnt_reg  <= '0;
                        vec_reg  <= vec_reg + 3'd1;
                        disagree <= disagree | (y_struct != y_other);
                        if (vec_fail) begin
                            fail_vec[vec_reg] <= 1'b1;
                            err_count         <= err_count + 4'd1;
                        end
                        if (vec_reg == LAST_VEC) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            // Include the vector being sampled right now in the verdict.
                            pass      <= (fail_vec == 8'h00) && !vec_fail;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
